// File: rtl/embertrail_data_bus_ctrl_if.sv
// rtl/embertrail_data_bus_ctrl_if.sv - core request and memory bank signal bundle for the data bus controller
interface embertrail_data_bus_ctrl_if #(
  parameter int ADDR_W = 10
) ();
  logic [31:0]       iDataAddrBus;
  logic [31:0]       iDataDataBus;
  logic              iDataMem1RW;
  logic              iDataMem2RW;
  logic              iData1BusEn;
  logic              iData2BusEn;
  logic [31:0]       oDataDataBus;
  logic              oDataReady;
  logic              oBusErr;
  logic              oBusy;
  logic [ADDR_W-1:0] oMemAddr;
  logic [31:0]       oMemWData;
  logic              oMem1Cs;
  logic              oMem2Cs;
  logic              oMem1We;
  logic              oMem2We;
  logic [31:0]       iMem1RData;
  logic [31:0]       iMem2RData;

  modport master (
    output iDataAddrBus, iDataDataBus, iDataMem1RW, iDataMem2RW, iData1BusEn, iData2BusEn,
    output iMem1RData, iMem2RData,
    input  oDataDataBus, oDataReady, oBusErr, oBusy, oMemAddr, oMemWData,
    input  oMem1Cs, oMem2Cs, oMem1We, oMem2We
  );

  modport slave (
    input  iDataAddrBus, iDataDataBus, iDataMem1RW, iDataMem2RW, iData1BusEn, iData2BusEn,
    input  iMem1RData, iMem2RData,
    output oDataDataBus, oDataReady, oBusErr, oBusy, oMemAddr, oMemWData,
    output oMem1Cs, oMem2Cs, oMem1We, oMem2We
  );
endinterface

// File: rtl/embertrail_data_bus_ctrl.sv
// rtl/embertrail_data_bus_ctrl.sv - wait-stated two-bank data memory controller with bus error detection
module embertrail_data_bus_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input logic                      iClock,
  input logic                      iReset,
  embertrail_data_bus_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              sel2_q, sel2_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic              req;
  logic              unused_addr_hi;

  assign req            = bus.iData1BusEn | bus.iData2BusEn;
  assign unused_addr_hi = ^bus.iDataAddrBus[31:ADDR_W+2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    sel2_d  = sel2_q;
    wr_d    = wr_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = bus.iDataAddrBus[ADDR_W+1:2];
          wdata_d = bus.iDataDataBus;
          // bank 1 wins a dual request; the error flag keeps it off the bus anyway
          sel2_d  = ~bus.iData1BusEn;
          wr_d    = bus.iData1BusEn ? bus.iDataMem1RW : bus.iDataMem2RW;
          err_d   = (bus.iData1BusEn & bus.iData2BusEn) | (bus.iDataAddrBus[1:0] != 2'b00);
          cnt_d   = WAIT_INIT;
          state_d = err_d ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!wr_q) begin
            rdata_d = sel2_q ? bus.iMem2RData : bus.iMem1RData;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      sel2_q  <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      sel2_q  <= sel2_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    bus.oMem1Cs      = (state_q == ACCESS) & ~sel2_q;
    bus.oMem2Cs      = (state_q == ACCESS) & sel2_q;
    bus.oMem1We      = (state_q == ACCESS) & ~sel2_q & wr_q;
    bus.oMem2We      = (state_q == ACCESS) & sel2_q & wr_q;
    bus.oDataReady   = (state_q == RESP);
    bus.oBusErr      = (state_q == RESP) & err_q;
    bus.oBusy        = (state_q != IDLE);
    bus.oMemAddr     = addr_q;
    bus.oMemWData    = wdata_q;
    bus.oDataDataBus = rdata_q;
  end
endmodule

// File: tb/tb_embertrail_data_bus_ctrl.sv
// tb/tb_embertrail_data_bus_ctrl.sv - directed self-checking bench for embertrail_data_bus_ctrl
module tb_embertrail_data_bus_ctrl;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  embertrail_data_bus_ctrl_if #(.ADDR_W(10)) b1 ();
  embertrail_data_bus_ctrl_if #(.ADDR_W(10)) b0 ();

  embertrail_data_bus_ctrl #(.ADDR_W(10), .WAIT_STATES(1)) dut1 (
    .iClock (clk),
    .iReset (rst),
    .bus    (b1.slave)
  );

  embertrail_data_bus_ctrl #(.ADDR_W(10), .WAIT_STATES(0)) dut0 (
    .iClock (clk),
    .iReset (rst),
    .bus    (b0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b1.iDataAddrBus = 32'd0; b1.iDataDataBus = 32'd0;
    b1.iDataMem1RW = 1'b0; b1.iDataMem2RW = 1'b0;
    b1.iData1BusEn = 1'b0; b1.iData2BusEn = 1'b0;
    b1.iMem1RData = 32'd0; b1.iMem2RData = 32'd0;
    b0.iDataAddrBus = 32'd0; b0.iDataDataBus = 32'd0;
    b0.iDataMem1RW = 1'b0; b0.iDataMem2RW = 1'b0;
    b0.iData1BusEn = 1'b0; b0.iData2BusEn = 1'b0;
    b0.iMem1RData = 32'd0; b0.iMem2RData = 32'd0;
  endtask

  task automatic test_reset();
    logic [7:0] flags;
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    flags = {b1.oMem1Cs, b1.oMem2Cs, b1.oMem1We, b1.oMem2We, b1.oDataReady, b1.oBusErr, b1.oBusy, b0.oBusy};
    checks++;
    if (flags !== 8'h00) begin
      errors++; $display("FAIL reset_flags got %b exp 00000000", flags);
    end
    checks++;
    if ({b1.oDataDataBus, b1.oMemWData, 22'd0, b1.oMemAddr} !== 96'd0) begin
      errors++; $display("FAIL reset_buses got %h/%h/%h exp 0", b1.oDataDataBus, b1.oMemWData, b1.oMemAddr);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_write_bank1();
    b1.iDataAddrBus = 32'h0000_0010; b1.iDataDataBus = 32'hDEADBEEF;
    b1.iDataMem1RW = 1'b1; b1.iData1BusEn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({b1.oMem1Cs, b1.oMem1We, b1.oMem2Cs, b1.oMem2We, b1.oDataReady} !== 5'b11000) begin
        errors++; $display("FAIL wr1_access%0d got %b exp 11000", i, {b1.oMem1Cs, b1.oMem1We, b1.oMem2Cs, b1.oMem2We, b1.oDataReady});
      end
    end
    checks++;
    if (b1.oMemAddr !== 10'd4 || b1.oMemWData !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr1_latch got addr %0d data %h exp 4 deadbeef", b1.oMemAddr, b1.oMemWData);
    end
    step();
    checks++;
    if ({b1.oDataReady, b1.oBusErr, b1.oMem1Cs, b1.oMem1We} !== 4'b1000) begin
      errors++; $display("FAIL wr1_ready got %b exp 1000", {b1.oDataReady, b1.oBusErr, b1.oMem1Cs, b1.oMem1We});
    end
    b1.iData1BusEn = 1'b0; b1.iDataMem1RW = 1'b0;
    step();
    checks++;
    if ({b1.oBusy, b1.oDataReady} !== 2'b00) begin
      errors++; $display("FAIL wr1_idle got %b exp 00", {b1.oBusy, b1.oDataReady});
    end
  endtask

  task automatic test_read_bank2();
    b1.iDataAddrBus = 32'h0000_0008; b1.iDataMem2RW = 1'b0;
    b1.iData2BusEn = 1'b1; b1.iMem2RData = 32'h12345678;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({b1.oMem2Cs, b1.oMem2We, b1.oMem1Cs, b1.oDataReady} !== 4'b1000) begin
        errors++; $display("FAIL rd2_access%0d got %b exp 1000", i, {b1.oMem2Cs, b1.oMem2We, b1.oMem1Cs, b1.oDataReady});
      end
    end
    step();
    checks++;
    if (b1.oDataReady !== 1'b1 || b1.oBusErr !== 1'b0 || b1.oDataDataBus !== 32'h12345678) begin
      errors++; $display("FAIL rd2_ready got rdy %b err %b data %h exp 1 0 12345678", b1.oDataReady, b1.oBusErr, b1.oDataDataBus);
    end
    b1.iData2BusEn = 1'b0; b1.iMem2RData = 32'hFFFF_0000;
    step();
  endtask

  task automatic test_misaligned();
    b1.iDataAddrBus = 32'h0000_0006; b1.iDataMem1RW = 1'b0;
    b1.iData1BusEn = 1'b1; b1.iMem1RData = 32'hBAD0_BAD0;
    step();
    checks++;
    if ({b1.oDataReady, b1.oBusErr, b1.oMem1Cs, b1.oMem1We, b1.oMem2Cs} !== 5'b11000) begin
      errors++; $display("FAIL misal_resp got %b exp 11000", {b1.oDataReady, b1.oBusErr, b1.oMem1Cs, b1.oMem1We, b1.oMem2Cs});
    end
    checks++;
    if (b1.oDataDataBus !== 32'h12345678) begin
      errors++; $display("FAIL misal_data got %h exp 12345678", b1.oDataDataBus);
    end
    b1.iData1BusEn = 1'b0;
    step();
    checks++;
    if ({b1.oBusy, b1.oDataReady, b1.oBusErr, b1.oMem1Cs} !== 4'b0000) begin
      errors++; $display("FAIL misal_after got %b exp 0000", {b1.oBusy, b1.oDataReady, b1.oBusErr, b1.oMem1Cs});
    end
  endtask

  task automatic test_dual_enable();
    b1.iDataAddrBus = 32'h0000_0020; b1.iDataDataBus = 32'h55AA55AA;
    b1.iDataMem1RW = 1'b1; b1.iDataMem2RW = 1'b1;
    b1.iData1BusEn = 1'b1; b1.iData2BusEn = 1'b1;
    step();
    checks++;
    if ({b1.oDataReady, b1.oBusErr, b1.oMem1Cs, b1.oMem1We, b1.oMem2Cs, b1.oMem2We} !== 6'b110000) begin
      errors++; $display("FAIL dual_resp got %b exp 110000", {b1.oDataReady, b1.oBusErr, b1.oMem1Cs, b1.oMem1We, b1.oMem2Cs, b1.oMem2We});
    end
    checks++;
    if (b1.oMemAddr !== 10'd8 || b1.oMemWData !== 32'h55AA55AA || b1.oDataDataBus !== 32'h12345678) begin
      errors++; $display("FAIL dual_latch got %0d %h %h exp 8 55aa55aa 12345678", b1.oMemAddr, b1.oMemWData, b1.oDataDataBus);
    end
    b1.iData1BusEn = 1'b0; b1.iData2BusEn = 1'b0;
    b1.iDataMem1RW = 1'b0; b1.iDataMem2RW = 1'b0;
    step();
    checks++;
    if ({b1.oBusy, b1.oMem2Cs, b1.oMem2We} !== 3'b000) begin
      errors++; $display("FAIL dual_after got %b exp 000", {b1.oBusy, b1.oMem2Cs, b1.oMem2We});
    end
  endtask

  task automatic test_reset_midflight();
    b1.iDataAddrBus = 32'h0000_0040; b1.iDataDataBus = 32'h0BADF00D;
    b1.iDataMem1RW = 1'b1; b1.iData1BusEn = 1'b1;
    step();
    checks++;
    if ({b1.oMem1Cs, b1.oMem1We} !== 2'b11) begin
      errors++; $display("FAIL rstmid_access got %b exp 11", {b1.oMem1Cs, b1.oMem1We});
    end
    rst = 1'b1;
    b1.iData1BusEn = 1'b0; b1.iDataMem1RW = 1'b0;
    step();
    checks++;
    if ({b1.oMem1Cs, b1.oMem1We, b1.oMem2Cs, b1.oMem2We, b1.oDataReady, b1.oBusErr, b1.oBusy} !== 7'd0) begin
      errors++; $display("FAIL rstmid_flags got %b exp 0000000", {b1.oMem1Cs, b1.oMem1We, b1.oMem2Cs, b1.oMem2We, b1.oDataReady, b1.oBusErr, b1.oBusy});
    end
    checks++;
    if (b1.oDataDataBus !== 32'd0 || b1.oMemWData !== 32'd0 || b1.oMemAddr !== 10'd0) begin
      errors++; $display("FAIL rstmid_buses got %h %h %h exp 0", b1.oDataDataBus, b1.oMemWData, b1.oMemAddr);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({b1.oDataReady, b1.oBusy, b1.oMem1Cs} !== 3'b000) begin
      errors++; $display("FAIL rstmid_noready got %b exp 000", {b1.oDataReady, b1.oBusy, b1.oMem1Cs});
    end
    b1.iDataAddrBus = 32'h0000_000C; b1.iData1BusEn = 1'b1; b1.iMem1RData = 32'hCAFEF00D;
    step();
    step();
    checks++;
    if ({b1.oMem1Cs, b1.oMem1We, b1.oDataReady} !== 3'b100 || b1.oMemAddr !== 10'd3) begin
      errors++; $display("FAIL rstmid_read_access got %b addr %0d exp 100 3", {b1.oMem1Cs, b1.oMem1We, b1.oDataReady}, b1.oMemAddr);
    end
    step();
    checks++;
    if (b1.oDataReady !== 1'b1 || b1.oBusErr !== 1'b0 || b1.oDataDataBus !== 32'hCAFEF00D) begin
      errors++; $display("FAIL rstmid_read_ready got %b %b %h exp 1 0 cafef00d", b1.oDataReady, b1.oBusErr, b1.oDataDataBus);
    end
    b1.iData1BusEn = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd [2];
    rd[0] = 32'h1111_1111;
    rd[1] = 32'h2222_2222;
    for (int t = 0; t < 2; t++) begin
      b0.iDataAddrBus = 32'(t * 4); b0.iDataMem1RW = 1'b0;
      b0.iData1BusEn = 1'b1; b0.iMem1RData = rd[t];
      step();
      checks++;
      if ({b0.oMem1Cs, b0.oMem1We, b0.oBusy, b0.oDataReady} !== 4'b1010 || b0.oMemAddr !== 10'(t)) begin
        errors++; $display("FAIL b2b%0d_access got %b addr %0d exp 1010 %0d", t, {b0.oMem1Cs, b0.oMem1We, b0.oBusy, b0.oDataReady}, b0.oMemAddr, t);
      end
      step();
      checks++;
      if ({b0.oDataReady, b0.oBusErr, b0.oBusy} !== 3'b101 || b0.oDataDataBus !== rd[t]) begin
        errors++; $display("FAIL b2b%0d_ready got %b %h exp 101 %h", t, {b0.oDataReady, b0.oBusErr, b0.oBusy}, b0.oDataDataBus, rd[t]);
      end
      b0.iData1BusEn = 1'b0;
      step();
      checks++;
      if ({b0.oBusy, b0.oDataReady, b0.oMem1Cs} !== 3'b000) begin
        errors++; $display("FAIL b2b%0d_idle got %b exp 000", t, {b0.oBusy, b0.oDataReady, b0.oMem1Cs});
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_write_bank1();
    test_read_bank2();
    test_misaligned();
    test_dual_enable();
    test_reset_midflight();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/embertrail_data_bus_ctrl.md
Name: embertrail_data_bus_ctrl

Overview:
Downstream data-memory bus controller for the Embertrail core. It accepts the core's data-side request signals (address, write data, per-bank RW and bus-enable strobes), runs a wait-stated access on one of two synchronous memory banks, and returns read data with a one-cycle ready pulse. It also flags misaligned or dual-bank requests as bus errors.

Parameters:
ADDR_W, 10, word-address width presented to each memory bank
WAIT_STATES, 1, extra ACCESS cycles per transfer (0..15)

Ports:
iClock  in  1  system clock, rising edge
iReset  in  1  synchronous, active-high reset
iDataAddrBus  in  32  byte address from core
iDataDataBus  in  32  write data from core
iDataMem1RW  in  1  bank 1 direction: 1=write, 0=read
iDataMem2RW  in  1  bank 2 direction: 1=write, 0=read
iData1BusEn  in  1  bank 1 request, held until oDataReady
iData2BusEn  in  1  bank 2 request, held until oDataReady
oDataDataBus  out  32  read data to core
oDataReady  out  1  one-cycle transfer-complete pulse
oBusErr  out  1  one-cycle error pulse, coincident with oDataReady
oBusy  out  1  high whenever state != IDLE
oMemAddr  out  ADDR_W  word address = iDataAddrBus[ADDR_W+1:2], latched
oMemWData  out  32  latched write data
oMem1Cs, oMem2Cs  out  1 each  bank chip selects
oMem1We, oMem2We  out  1 each  bank write enables
iMem1RData, iMem2RData  in  32 each  bank read data, valid while Cs high

Behaviour:
- Reset (sync, iReset high at edge): state=IDLE, wait counter=0, all outputs 0 including oDataDataBus; takes priority over any in-flight transfer; no Cs/We on the following cycle.
- States: IDLE, ACCESS, RESP.
- IDLE: if iData1BusEn|iData2BusEn at edge, latch address, write data, selected bank, direction; counter<=WAIT_STATES.
  - Both enables high: bank 1 selected, error flag set.
  - iDataAddrBus[1:0]!=0: error flag set.
  - Error flag set -> go straight to RESP, no Cs/We ever driven.
  - Otherwise -> ACCESS.
- ACCESS: selected oMemNCs=1; oMemNWe=1 iff latched direction is write; other bank's Cs/We=0. Counter decrements each cycle; on the edge with counter==0, read data of selected bank captured into oDataDataBus (reads only) -> RESP.
- RESP: oDataReady=1 for exactly this cycle; oBusErr=error flag; Cs/We=0. RESP -> IDLE unconditionally.
- Latency: request seen at edge E -> ACCESS occupies WAIT_STATES+1 cycles -> oDataReady high in cycle E+WAIT_STATES+2. Error: oDataReady in cycle E+1.
- oDataDataBus holds last successful read value; unchanged by writes and errors.
- Request inputs are ignored outside IDLE. A request still held during the RESP cycle is not re-accepted, because the core drops it after sampling ready. Back-to-back transfers are therefore spaced by one IDLE cycle minimum.
- oMemAddr/oMemWData hold latched values until the next accepted request.
- Address bits above ADDR_W+1 are ignored (wrap-around within bank).

Test Plan:
- WAIT_STATES=1. Bank1 write addr 0x0000_0010, data 0xDEADBEEF -> oMem1Cs=oMem1We=1 for 2 cycles, oMemAddr=4, oMemWData=0xDEADBEEF; oDataReady pulses at E+3, oBusErr=0.
- Bank2 read addr 0x0000_0008, iMem2RData=0x12345678 -> oMem2Cs=1, oMem2We=0 for 2 cycles; oDataReady at E+3 with oDataDataBus=0x12345678; oMem1Cs stays 0.
- Misaligned read addr 0x0000_0006 on bank1 -> no Cs/We ever; oDataReady=oBusErr=1 at E+1; oDataDataBus keeps its previous value.
- Both enables high, write 0x55AA55AA at addr 0x20 -> bank1 only, no write (error path); oBusErr=1 at E+1; oMem2Cs never asserted.
- iReset asserted in the first ACCESS cycle of a write -> next cycle all outputs 0, state IDLE, no oDataReady; subsequent read completes normally.
- WAIT_STATES=0: two back-to-back reads (addr 0x0, 0x4) -> each ready at E+2, one IDLE cycle between them, oBusy low only in that cycle.
